// File: rtl/decode_sequencer.sv
// decode_sequencer: fetch-entry FIFO feeding the decoder, with serialization/restart sequencing toward rename.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif
module decode_sequencer #(
    parameter int QDEPTH  = 4,
    parameter int M_WIDTH = `M_WIDTH,
    parameter int LG_PHT  = `LG_PHT_SZ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode64,
    input  logic               flush,
    input  logic               fq_valid,
    input  logic [31:0]        fq_insn,
    input  logic [M_WIDTH-1:0] fq_pc,
    input  logic               fq_pred,
    input  logic [LG_PHT-1:0]  fq_pht_idx,
    input  logic [M_WIDTH-1:0] fq_pred_target,
    output logic               fq_ready,
    output logic [31:0]        dec_insn,
    output logic [M_WIDTH-1:0] dec_pc,
    output logic               dec_pred,
    output logic [LG_PHT-1:0]  dec_pht_idx,
    output logic [M_WIDTH-1:0] dec_pred_target,
    output logic               dec_mode64,
    input  logic               dec_serializing,
    input  logic               dec_must_restart,
    output logic               uop_valid,
    input  logic               uop_ready,
    input  logic               rob_empty,
    output logic [1:0]         seq_state
);
    localparam int AW = $clog2(QDEPTH);
    localparam int EW = 32 + 2 * M_WIDTH + 1 + LG_PHT;

    typedef enum logic [1:0] {RUN = 2'd0, SER_WAIT = 2'd1, SER_HOLD = 2'd2, RESTART = 2'd3} state_t;

    state_t        state, next;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [EW-1:0] mem [QDEPTH];
    logic          nonempty, push, pop;

    assign nonempty   = count != '0;
    assign fq_ready   = (count != (AW+1)'(QDEPTH)) && !flush;
    assign push       = fq_valid && fq_ready;
    assign pop        = uop_valid && uop_ready && !flush;
    assign seq_state  = state;
    assign dec_mode64 = mode64;
    assign {dec_insn, dec_pc, dec_pred, dec_pht_idx, dec_pred_target} = mem[head];

    always_ff @(posedge clk)
        if (push) mem[tail] <= {fq_insn, fq_pc, fq_pred, fq_pht_idx, fq_pred_target};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= RUN;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            state <= next;
        end

    // A serializing head waits for an empty ROB before issue; after it issues,
    // younger ops wait again for it to retire (or for a flush if it restarts).
    always_comb begin
        next      = state;
        uop_valid = 1'b0;
        case (state)
            RUN: begin
                uop_valid = nonempty && (!dec_serializing || rob_empty);
                if (nonempty && dec_serializing && !rob_empty) next = SER_WAIT;
            end
            SER_WAIT: begin
                uop_valid = nonempty && rob_empty;
                if (!nonempty || !dec_serializing) next = RUN;
            end
            SER_HOLD: next = rob_empty ? RUN : SER_HOLD;
            default: next = RESTART;
        endcase
        if (pop && dec_serializing) next = dec_must_restart ? RESTART : SER_HOLD;
    end
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed checks of queueing, serialization and flush/reset behaviour.
module tb_decode_sequencer;
    localparam int MW = 64;
    localparam int LP = 10;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RDCYCLE = 32'hC000_2573;
    localparam logic [31:0] MONITOR = 32'h0010_0073;

    logic          clk = 1'b0, reset = 1'b0, mode64 = 1'b1, flush = 1'b0;
    logic          fq_valid = 1'b0, fq_pred = 1'b0, uop_ready = 1'b0, rob_empty = 1'b1;
    logic [31:0]   fq_insn = NOP;
    logic [MW-1:0] fq_pc = '0, fq_pred_target = '0;
    logic [LP-1:0] fq_pht_idx = '0;
    logic          fq_ready, dec_pred, dec_mode64, uop_valid, dec_serializing, dec_must_restart;
    logic [31:0]   dec_insn;
    logic [MW-1:0] dec_pc, dec_pred_target;
    logic [LP-1:0] dec_pht_idx;
    logic [1:0]    seq_state;
    int total = 0, bad = 0;

    decode_sequencer #(.QDEPTH(4), .M_WIDTH(MW), .LG_PHT(LP)) dut (
        .clk(clk), .reset(reset), .mode64(mode64), .flush(flush),
        .fq_valid(fq_valid), .fq_insn(fq_insn), .fq_pc(fq_pc), .fq_pred(fq_pred),
        .fq_pht_idx(fq_pht_idx), .fq_pred_target(fq_pred_target), .fq_ready(fq_ready),
        .dec_insn(dec_insn), .dec_pc(dec_pc), .dec_pred(dec_pred), .dec_pht_idx(dec_pht_idx),
        .dec_pred_target(dec_pred_target), .dec_mode64(dec_mode64),
        .dec_serializing(dec_serializing), .dec_must_restart(dec_must_restart),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .rob_empty(rob_empty), .seq_state(seq_state)
    );

    // Decoder stand-in: only RDCYCLE and MONITOR serialize; MONITOR also restarts.
    assign dec_serializing  = (dec_insn == RDCYCLE) || (dec_insn == MONITOR);
    assign dec_must_restart = dec_insn == MONITOR;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] insn, input logic [MW-1:0] pc);
        fq_valid = 1'b1;
        fq_insn  = insn;
        fq_pc    = pc;
        tick();
        fq_valid = 1'b0;
    endtask

    initial begin
        #12 reset = 1'b1;
        tick();
        chk("rst_fq_ready", fq_ready, 1);
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_state", seq_state, 0);
        chk("rst_count", dut.count, 0);

        for (int i = 0; i < 4; i++) push(NOP, 64'h100 + 4 * i);
        #1;
        chk("full_fq_ready", fq_ready, 0);
        chk("full_count", dut.count, 4);
        chk("full_uop_valid", uop_valid, 1);
        uop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b2b_valid", uop_valid, 1);
            chk("b2b_pc", dec_pc, 64'h100 + 4 * i);
            tick();
        end
        chk("drain_count", dut.count, 0);
        chk("drain_valid", uop_valid, 0);
        uop_ready = 1'b0;

        rob_empty = 1'b0;
        push(RDCYCLE, 64'h300);
        chk("ser_run_valid", uop_valid, 0);
        repeat (5) tick();
        chk("ser_wait_state", seq_state, 1);
        chk("ser_wait_valid", uop_valid, 0);
        rob_empty = 1'b1;
        #1;
        chk("ser_wait_go", uop_valid, 1);
        uop_ready = 1'b1;
        tick();
        chk("ser_hold_state", seq_state, 2);
        uop_ready = 1'b0;
        tick();
        chk("ser_hold_exit", seq_state, 0);

        push(MONITOR, 64'h400);
        chk("mon_valid", uop_valid, 1);
        uop_ready = 1'b1;
        tick();
        chk("restart_state", seq_state, 3);
        fq_valid = 1'b1;
        fq_insn  = NOP;
        fq_pc    = 64'h404;
        #1;
        chk("restart_fq_ready", fq_ready, 1);
        tick();
        fq_valid = 1'b0;
        chk("restart_count", dut.count, 1);
        chk("restart_valid", uop_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", dut.count, 0);
        chk("flush_state", seq_state, 0);

        uop_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(NOP, 64'h200 + 4 * i);
        fq_valid  = 1'b1;
        fq_pc     = 64'h210;
        uop_ready = 1'b1;
        tick();
        chk("fullpop_count", dut.count, 3);
        chk("fullpop_pc", dec_pc, 64'h204);
        tick();
        fq_valid = 1'b0;
        chk("pushpop_count", dut.count, 3);
        chk("pushpop_pc", dec_pc, 64'h208);
        for (int i = 0; i < 3; i++) begin
            chk("tail_drain_pc", dec_pc, 64'h208 + 4 * i);
            tick();
        end
        chk("tail_drain_count", dut.count, 0);

        uop_ready = 1'b0;
        push(NOP, 64'h500);
        fq_valid  = 1'b1;
        fq_pc     = 64'h504;
        uop_ready = 1'b1;
        flush     = 1'b1;
        #1;
        chk("fl_fq_ready", fq_ready, 0);
        tick();
        {flush, fq_valid, uop_ready} = 3'b000;
        chk("fl_count", dut.count, 0);
        chk("fl_valid", uop_valid, 0);
        chk("fl_state", seq_state, 0);

        rob_empty = 1'b0;
        push(RDCYCLE, 64'h600);
        push(NOP, 64'h604);
        push(NOP, 64'h608);
        chk("mid_wait_state", seq_state, 1);
        rob_empty = 1'b1;
        uop_ready = 1'b1;
        tick();
        rob_empty = 1'b0;
        uop_ready = 1'b0;
        chk("mid_hold_state", seq_state, 2);
        chk("mid_hold_count", dut.count, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", dut.count, 0);
        chk("arst_state", seq_state, 0);
        chk("arst_valid", uop_valid, 0);
        chk("arst_fq_ready", fq_ready, 1);
        #3 reset = 1'b1;
        rob_empty = 1'b1;
        uop_ready = 1'b1;
        tick();
        chk("post_rst_valid", uop_valid, 0);
        chk("post_rst_count", dut.count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
